// File: rtl/control_fsm.sv
// Multicycle RV32I main controller. One FSM state per micro-step; every
// datapath enable and mux select is registered alongside the state, so the
// outputs are a clean Moore decode of the state being entered. The only
// combinational path is the branch-taken PC write, which must react to the
// ALU compare (Zero / ALUResultLSB) produced in the BRANCH state itself.
module control_fsm #(
  parameter int MEM_WAIT = 1  // clock edges from address to read data valid (0..3)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_code,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResultLSB,
  output logic       adr_src,
  output logic       mem_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       PC_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JUMP,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    alu_op_t    alu_control;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

  // ALU operation for register/immediate arithmetic; SUB exists only for R-type.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7_5,
                                         input logic is_rtype);
    alu_op_t op;
    case (f3)
      3'd0:    op = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = f7_5 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction class dispatch taken at the end of DECODE.
  function automatic state_t dispatch(input logic [6:0] op);
    state_t s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEMADR;
      OP_RTYPE:          s = S_EXECR;
      OP_ITYPE:          s = S_EXECI;
      OP_BRANCH:         s = S_BRANCH;
      OP_JAL:            s = S_JAL;
      OP_JALR:           s = S_JALR;
      OP_LUI:            s = S_LUI;
      OP_AUIPC:          s = S_AUIPC;
      default:           s = S_TRAP;
    endcase
    return s;
  endfunction

  // Control word for a state; 'last' marks the final cycle of a memory wait.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic last,
                                        input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7_5);
    ctrl_t      c;
    logic [2:0] mem_imm;
    c           = '0;
    c.alu_control = ALU_ADD;
    mem_imm     = (op == OP_STORE) ? IMM_S : IMM_I;
    case (s)
      S_FETCH: begin
        if (last) begin
          c.ir_write   = 1'b1;
          c.pc_write   = 1'b1;
          c.result_src = 2'd2;
        end
      end
      S_DECODE: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd1;
        c.imm_src   = IMM_B;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'd2;
        c.alu_src_b = 2'd1;
        c.imm_src   = mem_imm;
      end
      S_MEMREAD: begin
        c.adr_src   = 1'b1;
        c.alu_src_a = 2'd2;
        c.alu_src_b = 2'd1;
        c.imm_src   = mem_imm;
      end
      S_MEMWB: begin
        c.result_src = 2'd1;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_src_a = 2'd2;
        c.alu_src_b = 2'd1;
        c.imm_src   = mem_imm;
      end
      S_EXECR: begin
        c.alu_src_a   = 2'd2;
        c.alu_control = alu_decode(f3, f7_5, 1'b1);
      end
      S_EXECI: begin
        c.alu_src_a   = 2'd2;
        c.alu_src_b   = 2'd1;
        c.imm_src     = IMM_I;
        c.alu_control = alu_decode(f3, f7_5, 1'b0);
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 2'd2;
        case (f3[2:1])
          2'b00:   c.alu_control = ALU_SUB;
          2'b10:   c.alu_control = ALU_SLT;
          2'b11:   c.alu_control = ALU_SLTU;
          default: c.alu_control = ALU_ADD;
        endcase
      end
      S_JAL: begin
        c.alu_src_a  = 2'd1;
        c.alu_src_b  = 2'd1;
        c.imm_src    = IMM_J;
        c.result_src = 2'd3;
        c.reg_write  = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a  = 2'd2;
        c.alu_src_b  = 2'd1;
        c.imm_src    = IMM_I;
        c.result_src = 2'd3;
        c.reg_write  = 1'b1;
      end
      S_JUMP: c.pc_write = 1'b1;
      S_LUI: begin
        c.alu_src_a = 2'd3;
        c.alu_src_b = 2'd1;
        c.imm_src   = IMM_U;
      end
      S_AUIPC: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd1;
        c.imm_src   = IMM_U;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state;
  state_t     next_state;
  logic [1:0] wait_cnt;
  logic [1:0] next_cnt;
  logic       wait_last;
  logic       next_last;
  ctrl_t      ctrl_q;
  logic       illegal_q;
  logic       branch_taken;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign wait_last     = (wait_cnt == WAIT_LAST);

  // Next-state and wait-counter selection for the current micro-step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = state;
    next_cnt   = 2'd0;
    case (state)
      S_FETCH: begin
        next_state = wait_last ? S_DECODE : S_FETCH;
        next_cnt   = wait_last ? 2'd0 : wait_cnt + 2'd1;
      end
      S_DECODE:  next_state = dispatch(op_code);
      S_MEMADR:  next_state = (op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        next_state = wait_last ? S_MEMWB : S_MEMREAD;
        next_cnt   = wait_last ? 2'd0 : wait_cnt + 2'd1;
      end
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_JUMP: next_state = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC:     next_state = S_ALUWB;
      S_BRANCH:  next_state = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
      S_JAL, S_JALR: next_state = S_JUMP;
      default:   next_state = S_TRAP;
    endcase
    next_last = (next_cnt == WAIT_LAST);
  end

  // State, wait counter, registered control word and sticky illegal flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      // NOTE: reset is synchronous and sampled only at the clock edge.
      state     <= S_FETCH;
      wait_cnt  <= 2'd0;
      ctrl_q    <= decode_ctrl(S_FETCH, MEM_WAIT == 0, op_code, funct3, funct7[5]);
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= next_cnt;
      ctrl_q    <= decode_ctrl(next_state, next_last, op_code, funct3, funct7[5]);
      illegal_q <= illegal_q | (next_state == S_TRAP);
    end
  end

  // Branch outcome from the ALU compare happening in BRANCH itself.
  always_comb begin
    branch_taken = 1'b0;
    if (state == S_BRANCH && funct3[2:1] != 2'b01)
      branch_taken = (funct3[2] ? ALUResultLSB : Zero) ^ funct3[0];
  end

  assign adr_src       = ctrl_q.adr_src;
  assign mem_write     = ctrl_q.mem_write;
  assign IR_write      = ctrl_q.ir_write;
  assign reg_write     = ctrl_q.reg_write;
  assign PC_write      = ctrl_q.pc_write | branch_taken;
  assign result_src    = ctrl_q.result_src;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign imm_src       = ctrl_q.imm_src;
  assign alu_control   = ctrl_q.alu_control;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm. A per-instruction reference model
// lists the expected control word for each cycle of the instruction, built
// directly from the micro-step rules; directed cases come first, then a
// randomized instruction stream.
module tb_control_fsm;

  localparam int MW = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_code;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       ALUResultLSB;
  logic       adr_src, mem_write, IR_write, reg_write, PC_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;

  control_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .ALUResultLSB(ALUResultLSB), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       adr, mw, irw, rw, pcw;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   skip;
  } step_t;

  vec_t  obs;
  step_t plan[$];
  bit    trapped;
  int    n_tests = 0;
  int    n_fail  = 0;

  assign obs = {adr_src, mem_write, IR_write, reg_write, PC_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};

  task automatic check(input string tag, input vec_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input vec_t v, input bit skip);
    step_t s;
    s.v    = v;
    s.skip = skip;
    plan.push_back(s);
  endtask

  // ALU code for arithmetic ops from the funct3 table.
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                         input bit rtype);
    logic [3:0] tbl[8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (f3 == 3'd0 && rtype && f7[5]) return 4'd1;
    if (f3 == 3'd5 && f7[5])          return 4'd7;
    return tbl[f3];
  endfunction

  // Expected per-cycle control words for one instruction, starting at FETCH.
  task automatic build_plan(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input logic lsb);
    vec_t e;
    vec_t wb;
    bit   taken;
    plan.delete();
    for (int i = 0; i < MW; i++) push('0, 0);
    e = '0; e.irw = 1; e.pcw = 1; e.rs = 2; push(e, 0);
    e = '0; e.a = 1; e.b = 1; e.imm = 2; push(e, 0);
    wb = '0; wb.rw = 1;
    case (op)
      7'h03: begin
        e = '0; e.a = 2; e.b = 1; e.imm = 0; push(e, 0);
        e.adr = 1;
        for (int i = 0; i <= MW; i++) push(e, 0);
        e = '0; e.rs = 1; e.rw = 1; push(e, 0);
      end
      7'h23: begin
        e = '0; e.a = 2; e.b = 1; e.imm = 1; push(e, 0);
        e.adr = 1; e.mw = 1; push(e, 0);
      end
      7'h33: begin
        e = '0; e.a = 2; e.alu = ref_alu(f3, f7, 1); push(e, 0);
        push(wb, 0);
      end
      7'h13: begin
        e = '0; e.a = 2; e.b = 1; e.alu = ref_alu(f3, f7, 0); push(e, 0);
        push(wb, 0);
      end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          push('0, 1);
          trapped = 1;
          e = '0; e.ill = 1; push(e, 0);
        end else begin
          case (f3)
            3'd0:          taken = z;
            3'd1:          taken = !z;
            3'd4, 3'd6:    taken = lsb;
            default:       taken = !lsb;
          endcase
          e = '0; e.a = 2;
          e.alu = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
          e.pcw = taken;
          push(e, 0);
        end
      end
      7'h6F, 7'h67: begin
        e = '0; e.b = 1; e.rs = 3; e.rw = 1;
        if (op == 7'h6F) begin e.a = 1; e.imm = 3; end
        else             begin e.a = 2; e.imm = 0; end
        push(e, 0);
        e = '0; e.pcw = 1; push(e, 0);
      end
      7'h37, 7'h17: begin
        e = '0; e.a = (op == 7'h37) ? 2'd3 : 2'd1; e.b = 1; e.imm = 4; push(e, 0);
        push(wb, 0);
      end
      default: begin
        trapped = 1;
        e = '0; e.ill = 1; push(e, 0);
      end
    endcase
  endtask

  // Runs one instruction from the first FETCH cycle; stops after step stop_at if >= 0.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic lsb,
                           input int stop_at);
    op_code = op; funct3 = f3; funct7 = f7; Zero = z; ALUResultLSB = lsb;
    build_plan(op, f3, f7, z, lsb);
    foreach (plan[i]) begin
      if (i > 0) @(negedge clk);
      if (!plan[i].skip) check($sformatf("%s.%0d", tag, i), plan[i].v);
      if (i == stop_at) return;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    vec_t e;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    trapped = 0;
    e = '0;
    if (MW == 0) begin e.irw = 1; e.pcw = 1; e.rs = 2; end
    check(tag, e);
  endtask

  task automatic check_trap_hold(input string tag, input int cycles);
    vec_t e;
    e = '0; e.ill = 1;
    for (int i = 0; i < cycles; i++) begin
      op_code = 7'h33;
      check($sformatf("%s.hold%0d", tag, i), e);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] ops[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0] op;
    logic [6:0] f7;
    reset = 1'b1; op_code = '0; funct3 = '0; funct7 = '0; Zero = 0; ALUResultLSB = 0;
    trapped = 0;
    @(negedge clk);
    do_reset("reset");

    // Directed cases
    run_instr("add",   7'h33, 3'd0, 7'h00, 0, 0, -1);
    run_instr("sub",   7'h33, 3'd0, 7'h20, 0, 0, -1);
    run_instr("srai",  7'h13, 3'd5, 7'h20, 0, 0, -1);
    run_instr("addi",  7'h13, 3'd0, 7'h20, 0, 0, -1);
    run_instr("lw",    7'h03, 3'd2, 7'h00, 0, 0, -1);
    run_instr("sw",    7'h23, 3'd2, 7'h00, 0, 0, -1);
    run_instr("bne_z", 7'h63, 3'd1, 7'h00, 1, 0, -1);
    run_instr("bne_n", 7'h63, 3'd1, 7'h00, 0, 0, -1);
    run_instr("bltu",  7'h63, 3'd6, 7'h00, 0, 1, -1);
    run_instr("jal",   7'h6F, 3'd0, 7'h00, 0, 0, -1);
    run_instr("jalr",  7'h67, 3'd0, 7'h00, 0, 0, -1);
    run_instr("lui",   7'h37, 3'd3, 7'h11, 0, 0, -1);
    run_instr("auipc", 7'h17, 3'd7, 7'h7F, 0, 0, -1);

    // Reset in the middle of a load's memory wait
    run_instr("lw_rst", 7'h03, 3'd2, 7'h00, 0, 0, MW + 3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_memread", '0);
    reset = 1'b0;
    run_instr("after_rst", 7'h33, 3'd4, 7'h00, 0, 0, -1);

    // Illegal opcode is sticky until reset
    run_instr("trap7f", 7'h7F, 3'd0, 7'h00, 0, 0, -1);
    check_trap_hold("trap7f", 3);
    do_reset("trap7f.reset");

    // Branch with reserved funct3
    run_instr("br_f3_2", 7'h63, 3'd2, 7'h00, 0, 0, -1);
    check_trap_hold("br_f3_2", 2);
    do_reset("br_f3_2.reset");

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : ops[$urandom_range(0, 8)];
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      run_instr($sformatf("rnd%0d_op%02h", n, op), op, 3'($urandom_range(0, 7)), f7,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      if (trapped) begin
        check_trap_hold($sformatf("rnd%0d", n), 1);
        do_reset($sformatf("rnd%0d.reset", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
